// File: rtl/fx3_gpif_reader_pkg.sv
// Shared types for the FX3 GPIF host-side reader: FSM states, pattern width,
// and a saturating counter helper.
package fx3_gpif_reader_pkg;

  localparam int PAT_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_AVAIL,
    REQUEST,
    LATENCY,
    CAPTURE,
    GAP
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fx3_gpif_reader_pattern_checker.sv
// Tracks the expected counter word and flags mismatches; the first word after
// a clear only seeds the counter, and every word resyncs it.
module fx3_gpif_reader_pattern_checker
  import fx3_gpif_reader_pkg::*;
#(
  parameter int PATTERN_MAX = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        sample,
  input  logic [15:0] data,
  output logic        mismatch
);

  logic [PAT_W-1:0] exp_q, exp_d;
  logic             valid_q, valid_d;
  logic [PAT_W-1:0] rx;

  always_comb begin
    rx       = data[PAT_W-1:0];
    exp_d    = exp_q;
    valid_d  = valid_q;
    mismatch = 1'b0;
    if (clear) begin
      valid_d = 1'b0;
    end else if (sample) begin
      mismatch = valid_q && ((data[15:PAT_W] != '0) || (rx != exp_q));
      exp_d    = (rx == PAT_W'(PATTERN_MAX)) ? '0 : rx + 1'b1;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fx3_gpif_reader.sv
// FX3 GPIF host emulation: requests fixed-length bursts from the capture path,
// checks them against the test counter pattern and keeps statistics.
module fx3_gpif_reader
  import fx3_gpif_reader_pkg::*;
#(
  parameter int BURST_WORDS  = 8192,
  parameter int READ_LATENCY = 2,   // must be >= 2
  parameter int GAP_CYCLES   = 4,
  parameter int PATTERN_MAX  = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        checkEnable,
  input  logic        dataAvailable,
  input  logic        bufferError,
  input  logic [15:0] dataIn,
  output logic        collectData,
  output logic        readData,
  output logic        testMode,
  output logic        busy,
  output logic        burstDone,
  output logic [31:0] burstCount,
  output logic [31:0] wordErrorCount,
  output logic [15:0] firstErrorWord,
  output logic        overflowSeen
);

  localparam int CNT_W = $clog2(BURST_WORDS + GAP_CYCLES + READ_LATENCY + 1);

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        collect_q, collect_d, read_q, read_d, test_q, test_d;
  logic        busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic        latched_q, latched_d;
  logic [31:0] burst_cnt_q, burst_cnt_d, err_cnt_q, err_cnt_d;
  logic [15:0] first_err_q, first_err_d;
  logic        mismatch;

  fx3_gpif_reader_pattern_checker #(.PATTERN_MAX(PATTERN_MAX)) u_chk (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_q == IDLE),
    .sample   ((state_q == CAPTURE) && checkEnable),
    .data     (dataIn),
    .mismatch (mismatch)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    collect_d   = collect_q;
    read_d      = 1'b0;
    done_d      = 1'b0;
    test_d      = checkEnable;
    burst_cnt_d = burst_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    latched_d   = latched_q;
    ovf_d       = ovf_q;
    // Outputs are registered, so they are set on the transition into a state.
    case (state_q)
      IDLE: if (enable) begin
        state_d   = ARM;
        collect_d = 1'b1;
      end
      ARM: state_d = WAIT_AVAIL;
      WAIT_AVAIL: begin
        if (!enable) begin
          state_d   = IDLE;
          collect_d = 1'b0;
        end else if (dataAvailable) begin
          state_d = REQUEST;
          read_d  = 1'b1;
        end
      end
      REQUEST: begin
        state_d = LATENCY;
        cnt_d   = '0;
      end
      LATENCY: begin
        if (cnt_q == CNT_W'(READ_LATENCY - 2)) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      CAPTURE: begin
        if (cnt_q == CNT_W'(BURST_WORDS - 1)) begin
          state_d     = GAP;
          cnt_d       = '0;
          done_d      = 1'b1;
          burst_cnt_d = sat_inc(burst_cnt_q);
        end else cnt_d = cnt_q + 1'b1;
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (enable) state_d = WAIT_AVAIL;
          else begin
            state_d   = IDLE;
            collect_d = 1'b0;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    if (mismatch) begin
      err_cnt_d = sat_inc(err_cnt_q);
      if (!latched_q) begin
        first_err_d = dataIn;
        latched_d   = 1'b1;
      end
    end
    if (bufferError && (state_q != IDLE)) ovf_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      collect_q   <= 1'b0;
      read_q      <= 1'b0;
      test_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      burst_cnt_q <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      latched_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      collect_q   <= collect_d;
      read_q      <= read_d;
      test_q      <= test_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      burst_cnt_q <= burst_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      latched_q   <= latched_d;
      ovf_q       <= ovf_d;
    end
  end

  assign collectData    = collect_q;
  assign readData       = read_q;
  assign testMode       = test_q;
  assign busy           = busy_q;
  assign burstDone      = done_q;
  assign burstCount     = burst_cnt_q;
  assign wordErrorCount = err_cnt_q;
  assign firstErrorWord = first_err_q;
  assign overflowSeen   = ovf_q;

endmodule

// File: tb/tb_fx3_gpif_reader.sv
// Bench for fx3_gpif_reader: a counter-pattern source answers readData, and a
// scoreboard of expected per-burst statistics is checked on every burstDone.
module tb_fx3_gpif_reader;

  localparam int BW = 8192;
  localparam int RL = 2;

  logic        clock = 1'b0;
  logic        reset, enable, checkEnable, dataAvailable, bufferError;
  logic [15:0] dataIn;
  logic        collectData, readData, testMode, busy, burstDone, overflowSeen;
  logic [31:0] burstCount, wordErrorCount;
  logic [15:0] firstErrorWord;

  fx3_gpif_reader dut (
    .clock(clock), .reset(reset), .enable(enable), .checkEnable(checkEnable),
    .dataAvailable(dataAvailable), .bufferError(bufferError), .dataIn(dataIn),
    .collectData(collectData), .readData(readData), .testMode(testMode),
    .busy(busy), .burstDone(burstDone), .burstCount(burstCount),
    .wordErrorCount(wordErrorCount), .firstErrorWord(firstErrorWord),
    .overflowSeen(overflowSeen)
  );

  always #8 clock = ~clock;

  typedef struct { int bc; int ec; } exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0;
  int rd_pulses = 0, done_pulses = 0, cyc = 0, rd_cyc = 0, done_cyc = 0;
  logic [9:0] src_pat;
  int src_idx, src_left, src_pending, corrupt_idx;

  // Capture-path model: first word valid RL cycles after the readData cycle.
  initial begin
    dataIn = 16'hDEAD; src_pat = '0; src_idx = 0; src_left = 0;
    src_pending = 0; corrupt_idx = -1;
    forever begin
      @(negedge clock);
      if (reset) begin
        src_left = 0; src_pending = 0;
      end
      if (src_pending > 0) begin
        src_pending--;
        if (src_pending == 0) begin src_left = BW; src_idx = 0; end
      end
      if (src_left > 0) begin
        dataIn  = (src_idx == corrupt_idx) ? 16'h0400 : {6'b0, src_pat};
        src_pat = (src_pat == 10'd1023) ? 10'd0 : src_pat + 10'd1;
        src_idx++; src_left--;
      end else dataIn = 16'hDEAD;
      if (readData === 1'b1 && !reset) src_pending = RL;
    end
  end

  // Scoreboard consumer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (readData === 1'b1) begin rd_pulses++; rd_cyc = cyc; end
      if (burstDone === 1'b1) begin
        done_pulses++; done_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_burst burstCount=%0d required no burst", burstCount);
        end else begin
          e = sb.pop_front();
          if (burstCount !== 32'(e.bc) || wordErrorCount !== 32'(e.ec)) begin
            errors++;
            $display("FAIL sb_burst got bc=%0d ec=%0d required bc=%0d ec=%0d",
                     burstCount, wordErrorCount, e.bc, e.ec);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (readData === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BW + 200; i++) begin
      @(negedge clock);
      if (burstDone === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic start_burst(output bit ok);
    dataAvailable = 1'b1;
    wait_read(ok);
    dataAvailable = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++;
    if ({collectData, readData, testMode, busy, burstDone, overflowSeen} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b required 000000",
        {collectData, readData, testMode, busy, burstDone, overflowSeen});
    end
    checks++;
    if (burstCount !== 0 || wordErrorCount !== 0 || firstErrorWord !== 0) begin
      errors++; $display("FAIL reset_counters got %0d %0d %h required 0 0 0000",
        burstCount, wordErrorCount, firstErrorWord);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b required 0", busy); end
  endtask

  task automatic test_ideal;
    bit ok;
    src_pat = 10'd5; corrupt_idx = -1; checkEnable = 1'b1; enable = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (testMode !== 1'b1) begin errors++; $display("FAIL test_mode got %b required 1", testMode); end
    checks++;
    if (collectData !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL armed got collect=%b busy=%b required 1 1", collectData, busy);
    end
    sb.push_back('{bc: 1, ec: 0});
    start_burst(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ideal_read got timeout required readData"); end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ideal_done got timeout required burstDone"); end
    @(negedge clock);
    checks++;
    if (done_cyc - rd_cyc !== BW + RL) begin
      errors++; $display("FAIL ideal_latency got %0d required %0d", done_cyc - rd_cyc, BW + RL);
    end
    checks++;
    if (burstDone !== 1'b0 || rd_pulses !== 1 || done_pulses !== 1) begin
      errors++; $display("FAIL ideal_pulses got done=%b rd=%0d dn=%0d required 0 1 1",
        burstDone, rd_pulses, done_pulses);
    end
  endtask

  // The source started at 5, so every burst crosses 1023 -> 0 several times.
  task automatic test_wrap;
    bit ok;
    for (int b = 2; b <= 3; b++) begin
      sb.push_back('{bc: b, ec: 0});
      start_burst(ok);
      wait_done(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_done got timeout required burst %0d", b); end
    end
    checks++;
    if (burstCount !== 3 || wordErrorCount !== 0) begin
      errors++; $display("FAIL wrap_totals got %0d %0d required 3 0", burstCount, wordErrorCount);
    end
    checks++;
    if (rd_pulses !== 3) begin errors++; $display("FAIL wrap_reads got %0d required 3", rd_pulses); end
  endtask

  task automatic test_corrupt;
    bit ok;
    corrupt_idx = 100;
    sb.push_back('{bc: 4, ec: 2});
    start_burst(ok);
    wait_done(ok);
    corrupt_idx = -1;
    checks++;
    if (!ok) begin errors++; $display("FAIL corrupt_done got timeout required burstDone"); end
    checks++;
    if (firstErrorWord !== 16'h0400) begin
      errors++; $display("FAIL first_error got %h required 0400", firstErrorWord);
    end
  endtask

  task automatic test_avail_gap;
    bit ok, bad;
    bad = 1'b0;
    sb.push_back('{bc: 5, ec: 2});
    repeat (50) begin
      @(negedge clock);
      if (readData !== 1'b0 || collectData !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL avail_hold got early read or collect drop required none"); end
    dataAvailable = 1'b1;
    @(negedge clock);
    checks++;
    if (readData !== 1'b1) begin errors++; $display("FAIL avail_read got %b required 1", readData); end
    dataAvailable = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL avail_done got timeout required burstDone"); end
  endtask

  task automatic test_enable_drop;
    bit ok;
    sb.push_back('{bc: 6, ec: 2});
    start_burst(ok);
    for (int i = 0; i < 100 && !(src_left > 0 && src_idx >= 10); i++) @(negedge clock);
    enable = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || collectData !== 1'b1) begin
      errors++; $display("FAIL drop_done got ok=%b collect=%b required 1 1", ok, collectData);
    end
    repeat (6) @(negedge clock);
    checks++;
    if (collectData !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL drop_idle got collect=%b busy=%b required 0 0", collectData, busy);
    end
    checks++;
    if (done_cyc - rd_cyc !== BW + RL) begin
      errors++; $display("FAIL drop_full_burst got %0d required %0d", done_cyc - rd_cyc, BW + RL);
    end
    // New session starts from an unrelated value; it must seed, not error.
    src_pat = 10'd700; enable = 1'b1;
    repeat (3) @(negedge clock);
    sb.push_back('{bc: 7, ec: 2});
    start_burst(ok);
    wait_done(ok);
    checks++;
    if (!ok || wordErrorCount !== 2) begin
      errors++; $display("FAIL reseed got ok=%b errs=%0d required 1 2", ok, wordErrorCount);
    end
  endtask

  task automatic test_overflow_reset;
    bit ok;
    bufferError = 1'b1;
    @(negedge clock);
    bufferError = 1'b0;
    checks++;
    if (overflowSeen !== 1'b1) begin errors++; $display("FAIL ovf_set got %b required 1", overflowSeen); end
    repeat (20) @(negedge clock);
    checks++;
    if (overflowSeen !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b required 1", overflowSeen); end
    start_burst(ok);
    for (int i = 0; i < 100 && !(src_left > 0 && src_idx >= 50); i++) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || burstCount !== 7) begin
      errors++; $display("FAIL pre_reset got busy=%b bc=%0d required 1 7", busy, burstCount);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({collectData, readData, testMode, busy, burstDone, overflowSeen} !== 6'b0 ||
        burstCount !== 0 || wordErrorCount !== 0 || firstErrorWord !== 0) begin
      errors++; $display("FAIL async_reset got flags=%b bc=%0d ec=%0d fe=%h required all 0",
        {collectData, readData, testMode, busy, burstDone, overflowSeen},
        burstCount, wordErrorCount, firstErrorWord);
    end
    enable = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d required 0", sb.size()); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; checkEnable = 1'b0;
    dataAvailable = 1'b0; bufferError = 1'b0;
    test_reset;
    test_ideal;
    test_wrap;
    test_corrupt;
    test_avail_gap;
    test_enable_drop;
    test_overflow_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
